tmp1075_poll_ctrl: RTL and testbench

//  Command sequencer for i2c_dri talking to a TMP1075N. After reset it writes the config register once.
//  It then polls the temperature register every SAMPLE_PERIOD cycles and publishes the signed integer degC byte.

---
 rtl/tmp1075_poll_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_tmp1075_poll_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmp1075_poll_ctrl.sv
// -----------------------------------------------------------------------------
// tmp1075_poll_ctrl
// Command sequencer for i2c_dri talking to a TMP1075N temperature sensor.
// After reset it writes the configuration register once. It then reads the
// temperature MSB byte at a fixed interval and publishes it as signed degC.
//
// Optional feature macro: ALERT_CMP_EN
//   When defined, adds the over_temp output, a hysteretic comparison of each
//   new temperature against HI_LIMIT / LO_LIMIT.
//
// Ports
//   clk         in   1   dri_clk from i2c_dri
//   rst         in   1   asynchronous active-high reset
//   en          in   1   polling allowed; when low, the current transfer
//                        finishes and the block then idles
//   i2c_exec    out  1   one-cycle transfer start strobe
//   bit_ctrl    out  1   constant 0 (8-bit register pointer)
//   i2c_rh_wl   out  1   1 = read, 0 = write
//   i2c_addr    out  16  register pointer (upper byte 0)
//   i2c_data_w  out  8   write data
//   i2c_data_r  in   8   read data, valid with i2c_done
//   i2c_done    in   1   transfer complete pulse
//   i2c_ack     in   1   sampled with i2c_done, 1 = slave NACK
//   temp        out  8   last good temperature, two's complement degC
//   temp_vld    out  1   one-cycle pulse when temp updates
//   busy        out  1   transfer outstanding (exec cycle through done cycle)
//   err         out  1   sticky: retries exhausted; cleared by rst only
//   fail_cnt    out  8   NACK/timeout event count, saturating at 255
//   over_temp   out  1   over-temperature flag (ALERT_CMP_EN only)
//
// Timing notes
//   The exec strobe is registered: it is loaded on the edge that enters an
//   issue state. The completion (or failure) cycle counts as period tick 0,
//   so a read strobe appears exactly SAMPLE_PERIOD cycles after the previous
//   done, and SAMPLE_PERIOD cycles after en is raised from an idle hold.
// -----------------------------------------------------------------------------
module tmp1075_poll_ctrl #(
    parameter logic [7:0]        CFG_ADDR      = 8'h01,
    parameter logic [7:0]        CFG_DATA      = 8'h61,
    parameter logic [7:0]        TEMP_ADDR     = 8'h00,
    parameter int unsigned       SAMPLE_PERIOD = 10_000,
    parameter int unsigned       TIMEOUT       = 65_535,
    parameter int unsigned       MAX_RETRY     = 3,
    parameter logic signed [7:0] HI_LIMIT      = 8'sd80,
    parameter logic signed [7:0] LO_LIMIT      = 8'sd75
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        i2c_exec,
    output logic        bit_ctrl,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic [7:0]  i2c_data_r,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic [7:0]  temp,
    output logic        temp_vld,
    output logic        busy,
    output logic        err,
    output logic [7:0]  fail_cnt
`ifdef ALERT_CMP_EN
    ,
    output logic        over_temp
`endif
);

    localparam int PW = (SAMPLE_PERIOD < 2) ? 1 : $clog2(SAMPLE_PERIOD);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_CFG_ISSUE = 3'd0,
        S_CFG_WAIT  = 3'd1,
        S_PERIOD    = 3'd2,
        S_RD_ISSUE  = 3'd3,
        S_RD_WAIT   = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   per_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [RW-1:0]   retry;
    logic            ret_cfg;     // failed transfer was the config write
    logic            load_exec;   // strobe a new transfer on this edge
    logic            load_cfg;    // that transfer is the config write
    logic            in_wait;
    logic            tmo_hit;
    logic            xfer_ok;
    logic            xfer_bad;
    logic            rd_ok;
    logic            retry_ok;

    assign bit_ctrl = 1'b0;

    assign in_wait  = (state == S_CFG_WAIT) || (state == S_RD_WAIT);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    // A done arriving on the abort cycle still counts as a completion.
    assign xfer_ok  = in_wait && i2c_done && !i2c_ack;
    assign xfer_bad = in_wait && ((i2c_done && i2c_ack) || (!i2c_done && tmo_hit));
    assign rd_ok    = xfer_ok && (state == S_RD_WAIT);
    assign retry_ok = (retry < RETRY_MAX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CFG_ISSUE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and transfer launch requests.
    always_comb begin
        next_state = state;
        load_exec  = 1'b0;
        load_cfg   = 1'b0;
        case (state)
            S_CFG_ISSUE: begin
                // Entered with the strobe already loaded on a retry; after
                // reset the strobe is launched here once en is high.
                if (i2c_exec) begin
                    next_state = S_CFG_WAIT;
                end else if (en) begin
                    load_exec = 1'b1;
                    load_cfg  = 1'b1;
                end else begin
                    next_state = S_CFG_ISSUE;
                end
            end
            S_CFG_WAIT, S_RD_WAIT: begin
                if (xfer_ok) begin
                    next_state = S_PERIOD;
                end else if (xfer_bad) begin
                    next_state = S_FAIL;
                end else begin
                    next_state = state;
                end
            end
            S_PERIOD: begin
                if (en && (per_cnt == PER_LAST)) begin
                    next_state = S_RD_ISSUE;
                    load_exec  = 1'b1;
                end else begin
                    next_state = S_PERIOD;
                end
            end
            S_RD_ISSUE: begin
                next_state = S_RD_WAIT;
            end
            S_FAIL: begin
                if (retry_ok) begin
                    load_exec = 1'b1;
                    if (ret_cfg) begin
                        next_state = S_CFG_ISSUE;
                        load_cfg   = 1'b1;
                    end else begin
                        next_state = S_RD_ISSUE;
                    end
                end else begin
                    // Give up; a failed config still moves on to polling.
                    next_state = S_PERIOD;
                end
            end
            default: begin
                next_state = S_CFG_ISSUE;
            end
        endcase
    end

    // Command strobe, command fields (held until the next launch) and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i2c_exec   <= 1'b0;
            i2c_rh_wl  <= 1'b0;
            i2c_addr   <= 16'h0000;
            i2c_data_w <= 8'h00;
            busy       <= 1'b0;
        end else begin
            i2c_exec <= load_exec;
            if (load_exec) begin
                i2c_rh_wl  <= !load_cfg;
                i2c_addr   <= {8'h00, (load_cfg ? CFG_ADDR : TEMP_ADDR)};
                i2c_data_w <= load_cfg ? CFG_DATA : 8'h00;
            end
            if (load_exec) begin
                busy <= 1'b1;
            end else if (in_wait && (i2c_done || tmo_hit)) begin
                busy <= 1'b0;
            end
        end
    end

    // Sample-period counter; the cycle before PERIOD is tick 0, !en parks it at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (state != S_PERIOD) begin
            per_cnt <= PW'(1);
        end else if (!en || (per_cnt == PER_LAST)) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + PW'(1);
        end
    end

    // Done timeout counter, live only while waiting for a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (!in_wait) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Retry bookkeeping, failure counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry    <= '0;
            ret_cfg  <= 1'b0;
            fail_cnt <= 8'h00;
            err      <= 1'b0;
        end else begin
            if (xfer_ok) begin
                retry <= '0;
            end
            if (xfer_bad) begin
                ret_cfg <= (state == S_CFG_WAIT);
            end
            if (state == S_FAIL) begin
                if (fail_cnt != 8'hFF) begin
                    fail_cnt <= fail_cnt + 8'd1;
                end
                if (retry_ok) begin
                    retry <= retry + RW'(1);
                end else begin
                    retry <= '0;
                    err   <= 1'b1;
                end
            end
        end
    end

    // Publish a successfully read temperature byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            temp     <= 8'h00;
            temp_vld <= 1'b0;
        end else begin
            temp_vld <= rd_ok;
            if (rd_ok) begin
                temp <= i2c_data_r;
            end
        end
    end

`ifdef ALERT_CMP_EN
    // Hysteretic over-temperature flag, updated together with temp_vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            over_temp <= 1'b0;
        end else if (rd_ok) begin
            if ($signed(i2c_data_r) >= HI_LIMIT) begin
                over_temp <= 1'b1;
            end else if ($signed(i2c_data_r) <= LO_LIMIT) begin
                over_temp <= 1'b0;
            end
        end
    end
`else
    logic unused_limits;
    assign unused_limits = ^{HI_LIMIT, LO_LIMIT};
`endif

endmodule

// File: tb/tb_tmp1075_poll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tmp1075_poll_ctrl
// Self-checking bench for tmp1075_poll_ctrl. An i2c_dri stand-in answers each
// exec strobe after a random latency with ACK+data, NACK, or silence. A small
// reference model tracks the expected temperature, failure count, sticky
// error and over-temperature flag from the sensor-level rules.
// -----------------------------------------------------------------------------
module tb_tmp1075_poll_ctrl;

    localparam int SP     = 20;
    localparam int TO     = 30;
    localparam int MR     = 3;
    localparam int K_ACK  = 0;
    localparam int K_NACK = 1;
    localparam int K_NONE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        i2c_exec;
    logic        bit_ctrl;
    logic        i2c_rh_wl;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w;
    logic [7:0]  i2c_data_r = 8'h00;
    logic        i2c_done   = 1'b0;
    logic        i2c_ack    = 1'b0;
    logic [7:0]  temp;
    logic        temp_vld;
    logic        busy;
    logic        err;
    logic [7:0]  fail_cnt;
`ifdef ALERT_CMP_EN
    logic        over_temp;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Captured at the exec strobe of the latest transfer.
    bit          got_exec;
    logic        ex_rh;
    logic [15:0] ex_addr;
    logic [7:0]  ex_dw;
    logic        ex_busy;
    logic [7:0]  ex_fail;
    logic        ex_err;
    int          ex_cyc;
    int          done_cyc;
    int          prev_done;
    int          stray_exec;
    int          busy_gap;
    logic [15:0] addr_at_done;

    // Reference model state.
    logic [7:0] m_temp   = 8'h00;
    logic [7:0] m_fail   = 8'h00;
    logic       m_err    = 1'b0;
    logic       m_over   = 1'b0;
    int         m_consec = 0;

    tmp1075_poll_ctrl #(
        .SAMPLE_PERIOD (SP),
        .TIMEOUT       (TO),
        .MAX_RETRY     (MR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .i2c_exec   (i2c_exec),
        .bit_ctrl   (bit_ctrl),
        .i2c_rh_wl  (i2c_rh_wl),
        .i2c_addr   (i2c_addr),
        .i2c_data_w (i2c_data_w),
        .i2c_data_r (i2c_data_r),
        .i2c_done   (i2c_done),
        .i2c_ack    (i2c_ack),
        .temp       (temp),
        .temp_vld   (temp_vld),
        .busy       (busy),
        .err        (err),
        .fail_cnt   (fail_cnt)
`ifdef ALERT_CMP_EN
        ,
        .over_temp  (over_temp)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_temp = 8'h00; m_fail = 8'h00; m_err = 1'b0; m_over = 1'b0; m_consec = 0;
    endtask

    task automatic model_ok(input bit is_read, input logic [7:0] d);
        m_consec = 0;
        if (is_read) begin
            m_temp = d;
            if ($signed(d) >= 80)      m_over = 1'b1;
            else if ($signed(d) <= 75) m_over = 1'b0;
        end
    endtask

    task automatic model_bad();
        if (m_fail < 8'd255) m_fail = m_fail + 8'd1;
        m_consec++;
        // One initial attempt plus MR retries, then the block gives up.
        if (m_consec > MR) begin
            m_err    = 1'b1;
            m_consec = 0;
        end
    endtask

    // ---------------- i2c_dri stand-in ----------------
    task automatic xfer(input int kind, input logic [7:0] rdata, input int bound, input bit drop_en);
        int lat;
        got_exec = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (i2c_exec === 1'b1) begin
                got_exec = 1;
                break;
            end
        end
        if (!got_exec) return;
        ex_rh   = i2c_rh_wl;
        ex_addr = i2c_addr;
        ex_dw   = i2c_data_w;
        ex_busy = busy;
        ex_fail = fail_cnt;
        ex_err  = err;
        ex_cyc  = cyc;
        if (drop_en) en = 1'b0;
        stray_exec = 0;
        busy_gap   = 0;
        lat = $urandom_range(6, 2);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (i2c_exec === 1'b1) stray_exec++;
            if (busy !== 1'b1) busy_gap++;
        end
        if (kind == K_NONE) return;
        addr_at_done = i2c_addr;
        done_cyc     = cyc;
        i2c_done     = 1'b1;
        i2c_ack      = (kind == K_NACK);
        i2c_data_r   = rdata;
        @(negedge clk);
        i2c_done   = 1'b0;
        i2c_ack    = 1'b0;
        i2c_data_r = 8'($urandom);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int cnt;
        rst = 1'b1; en = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if ({i2c_exec, busy, temp_vld, err} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {i2c_exec, busy, temp_vld, err}); end
        n_vec++; if (temp !== 8'h00) begin n_err++; $display("FAIL reset_temp: got %h want 00", temp); end
        n_vec++; if (fail_cnt !== 8'h00) begin n_err++; $display("FAIL reset_fail_cnt: got %h want 00", fail_cnt); end
        n_vec++; if ({bit_ctrl, i2c_rh_wl, i2c_addr, i2c_data_w} !== 26'h0) begin n_err++; $display("FAIL reset_cmd: got %h want 0", {bit_ctrl, i2c_rh_wl, i2c_addr, i2c_data_w}); end
`ifdef ALERT_CMP_EN
        n_vec++; if (over_temp !== 1'b0) begin n_err++; $display("FAIL reset_over_temp: got %b want 0", over_temp); end
`endif
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (i2c_exec === 1'b1) cnt++;
        end
        n_vec++; if (cnt != 0) begin n_err++; $display("FAIL idle_without_en: got %0d execs want 0", cnt); end
        model_reset();
    endtask

    task automatic test_config();
        en = 1'b1;
        xfer(K_ACK, 8'h00, 10, 1'b0);
        n_vec++; if (!got_exec) begin n_err++; $display("FAIL cfg_exec: got none want exec"); end
        n_vec++; if ({ex_rh, ex_addr, ex_dw} !== {1'b0, 16'h0001, 8'h61}) begin n_err++; $display("FAIL cfg_cmd: got %b/%h/%h want 0/0001/61", ex_rh, ex_addr, ex_dw); end
        n_vec++; if (ex_busy !== 1'b1 || busy_gap != 0) begin n_err++; $display("FAIL cfg_busy: got %b gaps %0d want 1 gaps 0", ex_busy, busy_gap); end
        n_vec++; if (addr_at_done !== 16'h0001 || stray_exec != 0) begin n_err++; $display("FAIL cfg_hold: got addr %h stray %0d want 0001 0", addr_at_done, stray_exec); end
        n_vec++; if (busy !== 1'b0 || temp_vld !== 1'b0) begin n_err++; $display("FAIL cfg_after: got busy %b vld %b want 0 0", busy, temp_vld); end
        model_ok(1'b0, 8'h00);
        prev_done = done_cyc;
    endtask

    task automatic test_read_values();
        logic [7:0] vals [0:1];
        vals[0] = 8'h19; vals[1] = 8'hF6;
        for (int k = 0; k < 2; k++) begin
            xfer(K_ACK, vals[k], SP + 10, 1'b0);
            model_ok(1'b1, vals[k]);
            n_vec++; if (!got_exec || ex_rh !== 1'b1 || ex_addr !== 16'h0000) begin n_err++; $display("FAIL rd_cmd[%0d]: got %0d/%b/%h want 1/1/0000", k, got_exec, ex_rh, ex_addr); end
            n_vec++; if (ex_cyc - prev_done != SP) begin n_err++; $display("FAIL rd_spacing[%0d]: got %0d want %0d", k, ex_cyc - prev_done, SP); end
            n_vec++; if (temp_vld !== 1'b1 || temp !== m_temp) begin n_err++; $display("FAIL rd_temp[%0d]: got vld %b temp %h want 1 %h", k, temp_vld, temp, m_temp); end
            prev_done = done_cyc;
            @(negedge clk);
            n_vec++; if (temp_vld !== 1'b0) begin n_err++; $display("FAIL rd_vld_pulse[%0d]: got %b want 0", k, temp_vld); end
        end
    endtask

    task automatic test_nack_retry();
        xfer(K_NACK, 8'h55, SP + TO + 10, 1'b0); model_bad();
        xfer(K_NACK, 8'h66, SP + TO + 10, 1'b0); model_bad();
        n_vec++; if (!got_exec || ex_rh !== 1'b1) begin n_err++; $display("FAIL nack_retry_cmd: got %0d/%b want 1/1", got_exec, ex_rh); end
        xfer(K_ACK, 8'h20, SP + TO + 10, 1'b0); model_ok(1'b1, 8'h20);
        n_vec++; if (!got_exec || ex_fail !== m_fail) begin n_err++; $display("FAIL nack_fail_cnt: got %h want %h", ex_fail, m_fail); end
        n_vec++; if (err !== m_err) begin n_err++; $display("FAIL nack_err: got %b want %b", err, m_err); end
        n_vec++; if (temp !== m_temp || temp_vld !== 1'b1) begin n_err++; $display("FAIL nack_temp: got %h/%b want %h/1", temp, temp_vld, m_temp); end
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        for (int k = 0; k < MR + 1; k++) begin
            xfer(K_NONE, 8'h00, SP + TO + 10, 1'b0);
            model_bad();
            n_vec++; if (!got_exec || ex_rh !== 1'b1 || busy_gap != 0) begin n_err++; $display("FAIL tmo_attempt[%0d]: got %0d/%b gaps %0d want 1/1 gaps 0", k, got_exec, ex_rh, busy_gap); end
        end
        repeat (TO + 2) @(negedge clk);
        n_vec++; if (fail_cnt !== m_fail) begin n_err++; $display("FAIL tmo_fail_cnt: got %h want %h", fail_cnt, m_fail); end
        n_vec++; if (err !== m_err || busy !== 1'b0) begin n_err++; $display("FAIL tmo_err: got err %b busy %b want %b 0", err, busy, m_err); end
        n_vec++; if (temp !== m_temp) begin n_err++; $display("FAIL tmo_temp_held: got %h want %h", temp, m_temp); end
        d = 8'($urandom);
        xfer(K_ACK, d, SP + 10, 1'b0);
        model_ok(1'b1, d);
        n_vec++; if (!got_exec || temp !== m_temp || err !== m_err) begin n_err++; $display("FAIL tmo_resume: got %0d temp %h err %b want 1 %h %b", got_exec, temp, err, m_temp, m_err); end
        prev_done = done_cyc;
    endtask

    task automatic test_en_drop();
        logic [7:0] d;
        int cnt;
        int r;
        d = 8'($urandom);
        xfer(K_ACK, d, SP + 10, 1'b1);
        model_ok(1'b1, d);
        n_vec++; if (temp_vld !== 1'b1 || temp !== m_temp) begin n_err++; $display("FAIL endrop_complete: got %b/%h want 1/%h", temp_vld, temp, m_temp); end
        cnt = 0;
        repeat (3 * SP) begin
            @(negedge clk);
            if (i2c_exec === 1'b1) cnt++;
        end
        n_vec++; if (cnt != 0) begin n_err++; $display("FAIL endrop_idle: got %0d execs want 0", cnt); end
        en = 1'b1;
        r  = cyc;
        d  = 8'($urandom);
        xfer(K_ACK, d, SP + 10, 1'b0);
        model_ok(1'b1, d);
        n_vec++; if (!got_exec || ex_cyc - r != SP) begin n_err++; $display("FAIL endrop_restart: got %0d want %0d", ex_cyc - r, SP); end
        n_vec++; if (temp !== m_temp) begin n_err++; $display("FAIL endrop_temp: got %h want %h", temp, m_temp); end
    endtask

    task automatic test_random();
        int kind;
        logic [7:0] d;
        for (int k = 0; k < 17; k++) begin
            kind = (k == 16 || $urandom_range(9, 0) >= 3) ? K_ACK : K_NACK;
            d    = 8'($urandom);
            xfer(kind, d, SP + TO + 10, 1'b0);
            n_vec++; if (!got_exec || ex_rh !== 1'b1 || ex_addr !== 16'h0000 || stray_exec != 0) begin n_err++; $display("FAIL rnd_cmd[%0d]: got %0d/%b/%h stray %0d", k, got_exec, ex_rh, ex_addr, stray_exec); end
            n_vec++; if (ex_fail !== m_fail || ex_err !== m_err) begin n_err++; $display("FAIL rnd_status[%0d]: got %h/%b want %h/%b", k, ex_fail, ex_err, m_fail, m_err); end
            if (kind == K_ACK) model_ok(1'b1, d);
            else               model_bad();
            n_vec++; if (temp !== m_temp || temp_vld !== (kind == K_ACK)) begin n_err++; $display("FAIL rnd_temp[%0d]: got %h/%b want %h", k, temp, temp_vld, m_temp); end
        end
    endtask

    task automatic test_rst_mid_cfg();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        xfer(K_NONE, 8'h00, 10, 1'b0);
        n_vec++; if (!got_exec || ex_addr !== 16'h0001 || busy !== 1'b1) begin n_err++; $display("FAIL rst_cfg_pending: got %0d/%h/%b want 1/0001/1", got_exec, ex_addr, busy); end
        rst = 1'b1;
        #1;
        n_vec++; if ({i2c_exec, busy, temp_vld, err, temp, fail_cnt, i2c_addr} !== 36'h0) begin n_err++; $display("FAIL rst_mid_outputs: got %h want 0", {i2c_exec, busy, temp_vld, err, temp, fail_cnt, i2c_addr}); end
        @(negedge clk);
        rst = 1'b0;
        xfer(K_ACK, 8'h00, 10, 1'b0);
        model_ok(1'b0, 8'h00);
        n_vec++; if (!got_exec || {ex_rh, ex_addr, ex_dw} !== {1'b0, 16'h0001, 8'h61}) begin n_err++; $display("FAIL rst_cfg_rewrite: got %0d %b/%h/%h want 0/0001/61", got_exec, ex_rh, ex_addr, ex_dw); end
    endtask

    task automatic test_alert();
        logic [7:0] vals [0:4];
        logic       exp_over [0:4];
        vals[0] = 8'd70; vals[1] = 8'd80; vals[2] = 8'd77; vals[3] = 8'd75; vals[4] = 8'd77;
        exp_over[0] = 1'b0; exp_over[1] = 1'b1; exp_over[2] = 1'b1; exp_over[3] = 1'b0; exp_over[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            xfer(K_ACK, vals[k], SP + 10, 1'b0);
            model_ok(1'b1, vals[k]);
            n_vec++; if (temp !== m_temp || temp_vld !== 1'b1) begin n_err++; $display("FAIL alert_temp[%0d]: got %h/%b want %h/1", k, temp, temp_vld, m_temp); end
`ifdef ALERT_CMP_EN
            n_vec++; if (over_temp !== exp_over[k]) begin n_err++; $display("FAIL alert_over[%0d]: got %b want %b", k, over_temp, exp_over[k]); end
`else
            if (exp_over[k] !== m_over) $display("note: model hysteresis differs at step %0d", k);
`endif
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_read_values();
        test_nack_retry();
        test_timeout();
        test_en_drop();
        test_random();
        test_rst_mid_cfg();
        test_alert();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
